alu_muldiv: RTL

Parametrised multi-cycle RV32M/RV64M multiply/divide unit that sits beside the single-cycle integer ALU in the execute stage. It takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations over a valid/ready handshake. It computes them iteratively, one bit per cycle, and holds the result until the writeback stage accepts it. A destination tag travels with each operation, and a flush input aborts in-flight work on a pipeline redirect.

---
 rtl/alu_muldiv_if.sv | 30 +++
 rtl/alu_muldiv.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// master: issue side (requests, flush, writeback ready).
// slave : the unit (in_ready, out_valid, result, out_tag, busy).
interface alu_muldiv_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  src1_value;
  logic [XLEN-1:0]  src2_value;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, op, src1_value, src2_value, in_tag, flush, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );

  modport slave (
    input  in_valid, op, src1_value, src2_value, in_tag, flush, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit, one bit per clock.
// Ports: clk, rst_n (async active-low), bus (alu_muldiv_if.slave) carrying
// the in_valid/in_ready request, op/src1/src2/in_tag operands, flush, and the
// out_valid/out_ready result with result/out_tag, plus busy.
module alu_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  opa;   // |src1|: multiplicand
  logic [XLEN-1:0]  opb;   // |src2|: divisor
  logic [PW-1:0]    prod;  // product; low half doubles as dividend/quotient
  logic [XLEN-1:0]  rem;   // partial remainder

  // Operand decode at accept time
  logic            sgn1, sgn2, neg1, neg2, div_zero, div_ovf, neg_fix;
  logic [XLEN-1:0] abs1, abs2, special_res;

  always_comb begin
    sgn1        = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                  (bus.op == 3'b100) || (bus.op == 3'b110);
    sgn2        = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    neg1        = sgn1 & bus.src1_value[XLEN-1];
    neg2        = sgn2 & bus.src2_value[XLEN-1];
    abs1        = neg1 ? (~bus.src1_value + XLEN'(1)) : bus.src1_value;
    abs2        = neg2 ? (~bus.src2_value + XLEN'(1)) : bus.src2_value;
    // Remainder follows the dividend; everything else follows the sign product
    neg_fix     = (bus.op[2] && bus.op[1]) ? neg1 : (neg1 ^ neg2);
    div_zero    = bus.op[2] && (bus.src2_value == '0);
    div_ovf     = bus.op[2] && !bus.op[0] &&
                  (bus.src1_value == MIN_NEG) && (bus.src2_value == '1);
    special_res = div_zero ? (bus.op[1] ? bus.src1_value : '1)
                           : (bus.op[1] ? '0 : bus.src1_value);
  end

  // One iteration of shift-add multiply and restoring divide
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  always_comb begin
    mul_sum   = {1'b0, prod[PW-1:XLEN]} + {1'b0, (prod[0] ? opa : '0)};
    div_shift = {rem, prod[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb};
    div_sub   = XLEN'(div_shift - {1'b0, opb});
  end

  // Final sign fix and result selection
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] div_sel, div_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? (~prod + PW'(1)) : prod;
    div_sel  = op_q[1] ? rem : prod[XLEN-1:0];
    div_fix  = neg_q ? (~div_sel + XLEN'(1)) : div_sel;
    if (op_q[2])
      fix_res = div_fix;
    else if (op_q[1:0] == 2'b00)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[PW-1:XLEN];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.result    <= '0;
      bus.out_tag   <= '0;
      op_q          <= '0;
      tag_q         <= '0;
      neg_q         <= 1'b0;
      cnt           <= '0;
      opa           <= '0;
      opb           <= '0;
      prod          <= '0;
      rem           <= '0;
    end else if (bus.flush) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q         <= bus.op;
            tag_q        <= bus.in_tag;
            neg_q        <= neg_fix;
            cnt          <= '0;
            opa          <= abs1;
            opb          <= abs2;
            prod         <= {{XLEN{1'b0}}, (bus.op[2] ? abs1 : abs2)};
            rem          <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            if (div_zero || div_ovf) begin
              bus.result    <= special_res;
              bus.out_tag   <= bus.in_tag;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(XLEN)) begin
            bus.result    <= fix_res;
            bus.out_tag   <= tag_q;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (op_q[2]) begin
              prod[XLEN-1:0] <= {prod[XLEN-2:0], div_ge};
              rem            <= div_ge ? div_sub : div_shift[XLEN-1:0];
            end else begin
              prod <= {mul_sum, prod[XLEN-1:1]};
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
